// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: register map, bit fields and FSM states.
package pwm_pkg;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_PERIOD = 2;
    localparam int REG_HIGH   = 3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int ST_VALID  = 0;
    localparam int ST_OVF    = 1;
    localparam int ST_LEVEL  = 2;
    localparam int ST_MISSED = 3;

    typedef enum logic [1:0] {IDLE, ARM, MEAS} cap_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// APB bus bundle between a master and the PWM capture slave.
interface pwm_capture_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/pwm_capture_sync.sv
// Brings the asynchronous PWM input into the pclk domain and flags its edges.
module pwm_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Two synchronizer stages followed by a delay stage used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;
endmodule

// File: rtl/pwm_capture.sv
// APB slave that measures period and high time of an external PWM signal.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    pwm_capture_if.slave  apb,
    input  logic          pwm_in,
    output logic          irq
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cap_state_t        r_state;
    cap_state_t        w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_hcnt;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  r_high;
    logic [CNT_W-1:0]  r_highShadow;
    logic              r_en;
    logic              r_irqEn;
    logic              r_valid;
    logic              r_ovf;
    logic              r_missed;
    logic              r_irq;

    logic              w_level;
    logic              w_rise;
    logic              w_fall;
    logic              w_unusedFall;
    logic              w_access;
    logic              w_err;
    logic              w_wrEn;
    logic              w_ctrlWr;
    logic              w_statWr;
    logic              w_periodRd;
    logic              w_clear;
    logic              w_restart;
    logic              w_capture;
    logic              w_overflow;
    logic [DATA_W-1:0] w_rdata;

    pwm_in_sync u_sync (
        .clk     (pclk),
        .rst_n   (presetn),
        .i_async (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_unusedFall = w_fall;

    // Bus decode; writes to read-only or unmapped words are rejected with an error.
    assign w_access   = apb.psel & apb.penable;
    assign w_err      = w_access & ((apb.paddr > ADDR_W'(REG_HIGH)) |
                        (apb.pwrite & ((apb.paddr == ADDR_W'(REG_PERIOD)) |
                                       (apb.paddr == ADDR_W'(REG_HIGH)))));
    assign w_wrEn     = w_access & apb.pwrite & ~w_err;
    assign w_ctrlWr   = w_wrEn & (apb.paddr == ADDR_W'(REG_CTRL));
    assign w_statWr   = w_wrEn & (apb.paddr == ADDR_W'(REG_STATUS));
    assign w_periodRd = w_access & ~apb.pwrite & (apb.paddr == ADDR_W'(REG_PERIOD));

    // Capture FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    // Next state: disabling always wins, otherwise arm, wait for a rise, and re-arm on overflow.
    always_comb begin
        w_nextState = r_state;
        if (!r_en) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_nextState = ARM;
                ARM:     if (w_rise) w_nextState = MEAS;
                MEAS:    if (w_overflow) w_nextState = ARM;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Per-state control strobes for the counters and result registers.
    always_comb begin
        w_clear    = (r_state == IDLE);
        w_restart  = r_en & w_rise & ((r_state == ARM) | (r_state == MEAS));
        w_capture  = r_en & w_rise & (r_state == MEAS);
        w_overflow = r_en & ~w_rise & (r_state == MEAS) & (r_cnt == CNT_MAX);
    end

    // Period and high-time counters, restarted on every rise.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else if (w_clear || w_overflow) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else if (w_restart) begin
            r_cnt  <= CNT_W'(1);
            r_hcnt <= CNT_W'(1);
        end else if (r_state == MEAS) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_hcnt <= r_hcnt + {{(CNT_W-1){1'b0}}, w_level};
        end
    end

    // Result registers, plus the HIGH shadow refreshed by each PERIOD read.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_period     <= '0;
            r_high       <= '0;
            r_highShadow <= '0;
        end else begin
            if (w_capture) begin
                r_period <= r_cnt;
                r_high   <= r_hcnt;
            end
            if (w_periodRd) r_highShadow <= r_high;
        end
    end

    // Control register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_en    <= 1'b0;
            r_irqEn <= 1'b0;
        end else if (w_ctrlWr) begin
            r_en    <= apb.pwdata[CTRL_EN];
            r_irqEn <= apb.pwdata[CTRL_IRQ_EN];
        end
    end

    // Sticky status flags; a hardware set in the same cycle overrides a software clear.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_missed <= 1'b0;
        end else begin
            r_valid  <= w_capture |
                        (r_valid & ~(w_statWr & apb.pwdata[ST_VALID]));
            r_ovf    <= w_overflow |
                        (r_ovf & ~(w_statWr & apb.pwdata[ST_OVF]));
            r_missed <= (w_capture & r_valid) |
                        (r_missed & ~(w_statWr & apb.pwdata[ST_MISSED]));
        end
    end

    // Level interrupt, registered one cycle behind the flags.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_irq <= 1'b0;
        else          r_irq <= r_irqEn & (r_valid | r_ovf);
    end

    // Read mux, driven only during read transfers.
    always_comb begin
        w_rdata = '0;
        if (apb.psel && !apb.pwrite) begin
            case (apb.paddr)
                ADDR_W'(REG_CTRL): begin
                    w_rdata[CTRL_EN]     = r_en;
                    w_rdata[CTRL_IRQ_EN] = r_irqEn;
                end
                ADDR_W'(REG_STATUS): begin
                    w_rdata[ST_VALID]  = r_valid;
                    w_rdata[ST_OVF]    = r_ovf;
                    w_rdata[ST_LEVEL]  = w_level;
                    w_rdata[ST_MISSED] = r_missed;
                end
                ADDR_W'(REG_PERIOD): w_rdata[CNT_W-1:0] = r_period;
                ADDR_W'(REG_HIGH):   w_rdata[CNT_W-1:0] = r_highShadow;
                default:             w_rdata = '0;
            endcase
        end
    end

    assign apb.prdata  = w_rdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = w_err;
    assign irq         = r_irq;
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed APB/PWM stimulus against a cycle-indexed model.
module tb_pwm_capture;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int MAXC   = 255;
    localparam int HIST   = 8192;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    logic pwm_in  = 1'b0;
    logic irq;

    pwm_capture_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    pwm_capture #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .apb     (apb),
        .pwm_in  (pwm_in),
        .irq     (irq)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    // Compare one value against its expectation and report a failure.
    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // PWM source: mode 0 = low, 1 = periodic, 2 = stuck high; changes on the falling clock edge.
    int genMode   = 0;
    int genPeriod = 100;
    int genHigh   = 25;
    int genPhase  = 0;

    initial begin
        forever begin
            @(negedge pclk);
            case (genMode)
                1: begin
                    pwm_in   = (genPhase < genHigh);
                    genPhase = (genPhase + 1) % genPeriod;
                end
                2:       pwm_in = 1'b1;
                default: begin
                    pwm_in   = 1'b0;
                    genPhase = 0;
                end
            endcase
        end
    end

    // Select a new PWM waveform.
    task automatic applyStimulus(input int mode, input int period, input int high);
        genPeriod = period;
        genHigh   = high;
        genPhase  = 0;
        genMode   = mode;
    endtask

    // Model state: the input sample taken at every clock edge, indexed by edge number since reset.
    bit smp [HIST];
    int kk        = 0;
    int mState    = 0;
    int mRiseAt   = 0;
    int mEn       = 0;
    int mIrqEn    = 0;
    int mValid    = 0;
    int mOvf      = 0;
    int mMissed   = 0;
    int mPeriod   = 0;
    int mHigh     = 0;
    int mShadow   = 0;
    int mIrq      = 0;

    function automatic int smpAt(input int i);
        if (i < 0 || i >= HIST) return 0;
        return int'(smp[i]);
    endfunction

    // A rise of the input is seen by the block two edges after it is first sampled.
    function automatic int riseSeen(input int edgeIdx);
        return (smpAt(edgeIdx - 2) == 1 && smpAt(edgeIdx - 3) == 0) ? 1 : 0;
    endfunction

    // Model update at each clock edge, evaluated from pre-edge values.
    initial begin
        int rise, acc, err, wr, setV, setO, setM, clrV, clrO, clrM, nIrq, hsum, addr, wdat;
        forever begin
            @(posedge pclk or negedge presetn);
            if (!presetn) begin
                kk = 0; mState = 0; mRiseAt = 0; mEn = 0; mIrqEn = 0;
                mValid = 0; mOvf = 0; mMissed = 0; mPeriod = 0; mHigh = 0;
                mShadow = 0; mIrq = 0;
            end else begin
                addr = int'(apb.paddr);
                wdat = int'(apb.pwdata);
                rise = riseSeen(kk);
                acc  = (apb.psel && apb.penable) ? 1 : 0;
                err  = (acc == 1 && (addr > 3 || (apb.pwrite && (addr == 2 || addr == 3)))) ? 1 : 0;
                wr   = (acc == 1 && apb.pwrite && err == 0) ? 1 : 0;
                setV = 0; setO = 0; setM = 0;
                nIrq = (mIrqEn != 0 && (mValid != 0 || mOvf != 0)) ? 1 : 0;
                if (acc == 1 && !apb.pwrite && addr == 2) mShadow = mHigh;
                case (mState)
                    0: if (mEn != 0) mState = 1;
                    1: begin
                        if (mEn == 0) mState = 0;
                        else if (rise == 1) begin
                            mState  = 2;
                            mRiseAt = kk;
                        end
                    end
                    default: begin
                        if (mEn == 0) mState = 0;
                        else if (rise == 1) begin
                            hsum = 0;
                            for (int e = mRiseAt - 2; e <= kk - 3; e++) hsum += smpAt(e);
                            mPeriod = kk - mRiseAt;
                            mHigh   = hsum;
                            setV    = 1;
                            setM    = mValid;
                            mRiseAt = kk;
                        end else if (kk - mRiseAt == MAXC) begin
                            setO   = 1;
                            mState = 1;
                        end
                    end
                endcase
                clrV = 0; clrO = 0; clrM = 0;
                if (wr == 1 && addr == 0) begin
                    mEn    = wdat & 1;
                    mIrqEn = (wdat >> 1) & 1;
                end
                if (wr == 1 && addr == 1) begin
                    clrV = wdat & 1;
                    clrO = (wdat >> 1) & 1;
                    clrM = (wdat >> 3) & 1;
                end
                mValid  = (setV == 1 || (mValid == 1 && clrV == 0)) ? 1 : 0;
                mOvf    = (setO == 1 || (mOvf == 1 && clrO == 0)) ? 1 : 0;
                mMissed = (setM == 1 || (mMissed == 1 && clrM == 0)) ? 1 : 0;
                mIrq    = nIrq;
                if (kk < HIST) smp[kk] = pwm_in;
                kk++;
            end
        end
    end

    // Expected read data from the model for the current bus state.
    function automatic int expRead();
        int a;
        a = int'(apb.paddr);
        if (!(apb.psel && !apb.pwrite)) return 0;
        case (a)
            0:       return (mIrqEn << 1) | mEn;
            1:       return (mMissed << 3) | (smpAt(kk - 2) << 2) | (mOvf << 1) | mValid;
            2:       return mPeriod;
            3:       return mShadow;
            default: return 0;
        endcase
    endfunction

    function automatic int expErr();
        int a;
        a = int'(apb.paddr);
        if (!(apb.psel && apb.penable)) return 0;
        return (a > 3 || (apb.pwrite && (a == 2 || a == 3))) ? 1 : 0;
    endfunction

    // Cycle-by-cycle comparison of all outputs against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge pclk);
            checkOutput("irq", int'(irq), mIrq);
            checkOutput("pready", int'(apb.pready), 1);
            checkOutput("pslverr", int'(apb.pslverr), expErr());
            checkOutput("prdata", int'(apb.prdata), expRead());
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // APB write; starts and ends just after a rising edge.
    task automatic apbWrite(input int addr, input int data, output int err);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b1;
        apb.paddr   = ADDR_W'(addr);
        apb.pwdata  = DATA_W'(data);
        @(posedge pclk); #1;
        apb.penable = 1'b1;
        @(negedge pclk);
        err = int'(apb.pslverr);
        @(posedge pclk); #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
    endtask

    // APB read; starts and ends just after a rising edge.
    task automatic apbRead(input int addr, output int data, output int err);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = ADDR_W'(addr);
        @(posedge pclk); #1;
        apb.penable = 1'b1;
        @(negedge pclk);
        data = int'(apb.prdata);
        err  = int'(apb.pslverr);
        @(posedge pclk); #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
    endtask

    task automatic wr(input int addr, input int data);
        int e;
        apbWrite(addr, data, e);
    endtask

    task automatic rdCheck(input string name, input int addr, input int mask, input int exp);
        int d, e;
        apbRead(addr, d, e);
        checkOutput(name, d & mask, exp);
    endtask

    // Wait for the bench-driven input to go high, bounded by a cycle budget.
    task automatic waitPwmRise(input int budget);
        logic prev;
        bit   seen;
        prev = pwm_in;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge pclk); #1;
            if (pwm_in && !prev) seen = 1'b1;
            prev = pwm_in;
        end
        checkOutput("pwm rise within budget", int'(seen), 1);
    endtask

    initial begin
        int d, e;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;
        waitCycles(3);
        presetn = 1'b1;
        waitCycles(2);

        $display("[TB] reset state");
        rdCheck("reset CTRL", 0, 16'hFFFF, 0);
        rdCheck("reset STATUS", 1, 16'hFFFF, 0);
        rdCheck("reset PERIOD", 2, 16'hFFFF, 0);
        rdCheck("reset HIGH", 3, 16'hFFFF, 0);
        checkOutput("reset irq", int'(irq), 0);

        $display("[TB] basic capture 100/25");
        wr(0, 1);
        applyStimulus(1, 100, 25);
        waitCycles(60);
        rdCheck("first rise no capture", 1, 1, 0);
        waitCycles(260);
        rdCheck("VALID and MISSED after captures", 1, 9, 9);
        rdCheck("PERIOD 100", 2, 16'hFFFF, 100);
        rdCheck("HIGH 25", 3, 16'hFFFF, 25);

        $display("[TB] W1C race on capture cycle");
        wr(1, 9);
        rdCheck("flags cleared", 1, 9, 0);
        waitPwmRise(300);
        wr(1, 1);
        rdCheck("VALID survives racing W1C", 1, 9, 1);

        $display("[TB] stuck-high input overflow");
        wr(0, 0);
        applyStimulus(0, 100, 25);
        waitCycles(10);
        wr(1, 11);
        wr(0, 1);
        waitCycles(5);
        applyStimulus(2, 100, 25);
        waitCycles(300);
        rdCheck("STATUS OVF and LEVEL", 1, 16'hFFFF, 6);
        rdCheck("PERIOD unchanged after OVF", 2, 16'hFFFF, 100);

        $display("[TB] coherent read and irq");
        wr(1, 2);
        wr(0, 3);
        rdCheck("PERIOD before new capture", 2, 16'hFFFF, 100);
        applyStimulus(0, 40, 10);
        waitCycles(5);
        applyStimulus(1, 40, 10);
        waitCycles(30);
        rdCheck("re-armed: first rise no capture", 1, 1, 0);
        waitCycles(60);
        rdCheck("HIGH returns old shadow", 3, 16'hFFFF, 25);
        checkOutput("irq high after VALID", int'(irq), 1);
        rdCheck("PERIOD 40", 2, 16'hFFFF, 40);
        rdCheck("HIGH 10", 3, 16'hFFFF, 10);
        wr(0, 2);
        waitCycles(3);
        wr(1, 11);
        waitCycles(2);
        checkOutput("irq low after W1C", int'(irq), 0);

        $display("[TB] APB errors");
        apbWrite(2, 16'h1234, e);
        checkOutput("pslverr write PERIOD", e, 1);
        apbRead(2, d, e);
        checkOutput("PERIOD kept after bad write", d, 40);
        checkOutput("pslverr good read", e, 0);
        apbRead(7, d, e);
        checkOutput("pslverr read 7", e, 1);
        checkOutput("prdata read 7", d, 0);
        apbWrite(9, 3, e);
        checkOutput("pslverr write 9", e, 1);
        rdCheck("CTRL kept after bad write", 0, 16'hFFFF, 2);

        $display("[TB] reset mid-measurement");
        wr(0, 1);
        waitCycles(60);
        presetn = 1'b0;
        waitCycles(3);
        presetn = 1'b1;
        waitCycles(1);
        rdCheck("post-reset CTRL", 0, 16'hFFFF, 0);
        rdCheck("post-reset STATUS flags", 1, 11, 0);
        rdCheck("post-reset PERIOD", 2, 16'hFFFF, 0);
        rdCheck("post-reset HIGH", 3, 16'hFFFF, 0);
        checkOutput("post-reset irq", int'(irq), 0);
        waitCycles(100);
        rdCheck("no capture while disabled", 1, 1, 0);
        rdCheck("PERIOD still 0", 2, 16'hFFFF, 0);
        wr(0, 1);
        waitCycles(100);
        rdCheck("capture after re-enable", 2, 16'hFFFF, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
